fsk_symbol_sequencer: RTL and testbench

//  Frames bytes into a UART-style FSK symbol stream and drives the tone-enable inputs of the dual-tone PDM generator:

---
 rtl/fsk_symbol_sequencer_pkg.sv | 26 ++
 rtl/fsk_symbol_sequencer_if.sv | 11 +
 rtl/fsk_symbol_sequencer_timer.sv | 34 +++
 rtl/fsk_symbol_sequencer.sv | 158 +++++++++++++++
 tb/tb_fsk_symbol_sequencer.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fsk_symbol_sequencer_pkg.sv
// Shared types and helpers for the FSK symbol sequencer: state encoding,
// tone polarity constants and frame-length arithmetic.
package fsk_symbol_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_START    = 3'd2,
    ST_DATA     = 3'd3,
    ST_STOP     = 3'd4,
    ST_GUARD    = 3'd5
  } fsk_state_e;

  localparam logic MARK  = 1'b1;
  localparam logic SPACE = 1'b0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Symbols per frame: preamble + start + payload + stop.
  function automatic int frame_symbols(input int preamble_bits, input int data_bits);
    return preamble_bits + data_bits + 2;
  endfunction

endpackage

// File: rtl/fsk_symbol_sequencer_if.sv
// Byte-source handshake between the CPU/FIFO and the symbol sequencer.
interface fsk_symbol_sequencer_if #(
  parameter int DATA_BITS = 8
) ();
  logic                 s_valid;
  logic [DATA_BITS-1:0] s_data;
  logic                 s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/fsk_symbol_sequencer_timer.sv
// Loadable down-counter; tc is high while the count sits at zero, which marks
// the last cycle of the current symbol or guard gap.
module fsk_symbol_sequencer_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/fsk_symbol_sequencer.sv
// Frames bytes into preamble/start/data/stop FSK symbols driving the mark and
// space tone enables of the PDM generator, with a silent guard gap per frame.
//   state    | meaning
//   IDLE     | no frame, waiting for an accepted byte
//   PREAMBLE | alternating mark/space training symbols
//   START    | one space symbol
//   DATA     | payload bits, order set by MSB_FIRST
//   STOP     | one mark symbol
//   GUARD    | both tones off; burst accept allowed on its last cycle
module fsk_symbol_sequencer
  import fsk_symbol_sequencer_pkg::*;
#(
  parameter int SYMBOL_CYCLES = 100000,
  parameter int GUARD_CYCLES  = 16,
  parameter int PREAMBLE_BITS = 8,
  parameter int DATA_BITS     = 8,
  parameter bit MSB_FIRST     = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  fsk_symbol_sequencer_if.slave  s_if,
  output logic                   tone_mark_en,
  output logic                   tone_space_en,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int TW = $clog2(max_int(SYMBOL_CYCLES, GUARD_CYCLES));
  localparam int BW = $clog2(max_int(DATA_BITS, PREAMBLE_BITS) + 1);
  localparam logic [TW-1:0] SYM_LOAD   = TW'(SYMBOL_CYCLES - 1);
  localparam logic [TW-1:0] GUARD_LOAD = TW'(GUARD_CYCLES - 1);
  localparam logic [BW-1:0] PRE_LAST   = BW'(PREAMBLE_BITS - 1);
  localparam logic [BW-1:0] DATA_LAST  = BW'(DATA_BITS - 1);

  fsk_state_e           state_q, state_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 mark_q, mark_d, space_q, space_d, done_q, done_d;
  logic                 tmr_load, tmr_tc, s_ready, accept;
  logic [TW-1:0]        tmr_val;
  logic                 sym_on, sym_val, data_bit;

  assign s_ready = rst_n & enable &
                   ((state_q == ST_IDLE) | ((state_q == ST_GUARD) & tmr_tc));
  assign s_if.s_ready = s_ready;
  assign accept = s_if.s_valid & s_ready;

  fsk_symbol_sequencer_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    tmr_load  = 1'b0;
    tmr_val   = SYM_LOAD;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: if (accept) begin
        data_d    = s_if.s_data;
        tmr_load  = 1'b1;
        bit_cnt_d = '0;
        state_d   = (PREAMBLE_BITS == 0) ? ST_START : ST_PREAMBLE;
      end
      ST_PREAMBLE: if (tmr_tc) begin
        tmr_load = 1'b1;
        if (bit_cnt_q == PRE_LAST) begin
          state_d   = ST_START;
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
      ST_START: if (tmr_tc) begin
        tmr_load  = 1'b1;
        bit_cnt_d = '0;
        state_d   = ST_DATA;
      end
      ST_DATA: if (tmr_tc) begin
        tmr_load = 1'b1;
        if (bit_cnt_q == DATA_LAST) begin
          state_d   = ST_STOP;
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
      ST_STOP: if (tmr_tc) begin
        tmr_load = 1'b1;
        tmr_val  = GUARD_LOAD;
        done_d   = 1'b1;
        state_d  = ST_GUARD;
      end
      ST_GUARD: if (tmr_tc) begin
        if (accept) begin
          data_d    = s_if.s_data;
          tmr_load  = 1'b1;
          bit_cnt_d = '0;
          state_d   = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Tones are encoded from the next state so they switch on the same edge as the FSM.
  always_comb begin
    data_bit = 1'b0;
    for (int i = 0; i < DATA_BITS; i++) begin
      if (int'(bit_cnt_d) == i) begin
        data_bit = MSB_FIRST ? data_q[DATA_BITS-1-i] : data_q[i];
      end
    end
    sym_on  = 1'b1;
    sym_val = SPACE;
    case (state_d)
      ST_PREAMBLE: sym_val = bit_cnt_d[0] ? SPACE : MARK;
      ST_START:    sym_val = SPACE;
      ST_DATA:     sym_val = data_bit;
      ST_STOP:     sym_val = MARK;
      default:     sym_on  = 1'b0;
    endcase
    mark_d  = sym_on & (sym_val == MARK);
    space_d = sym_on & (sym_val == SPACE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      data_q    <= '0;
      mark_q    <= 1'b0;
      space_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      mark_q    <= mark_d;
      space_q   <= space_d;
      done_q    <= done_d;
    end
  end

  assign tone_mark_en  = mark_q;
  assign tone_space_en = space_q;
  assign busy          = (state_q != ST_IDLE);
  assign frame_done    = done_q;

endmodule

// File: tb/tb_fsk_symbol_sequencer.sv
// Scoreboard bench: the driver pushes the expected frame on every accept, and
// per-DUT monitors rebuild each tone frame and compare it against the queue.
module tb_fsk_symbol_sequencer;
  localparam int SYM = 4;
  localparam int GRD = 2;
  localparam int PRE = 4;
  localparam int DB  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b1;
  logic mark0, space0, busy0, done0;
  logic mark1, space1, busy1, done1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fsk_symbol_sequencer_if #(.DATA_BITS(DB)) if0 ();
  fsk_symbol_sequencer_if #(.DATA_BITS(DB)) if1 ();

  fsk_symbol_sequencer #(.SYMBOL_CYCLES(SYM), .GUARD_CYCLES(GRD), .PREAMBLE_BITS(PRE),
                         .DATA_BITS(DB), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .s_if(if0.slave),
    .tone_mark_en(mark0), .tone_space_en(space0), .busy(busy0), .frame_done(done0));

  fsk_symbol_sequencer #(.SYMBOL_CYCLES(SYM), .GUARD_CYCLES(GRD), .PREAMBLE_BITS(PRE),
                         .DATA_BITS(DB), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .s_if(if1.slave),
    .tone_mark_en(mark1), .tone_space_en(space1), .busy(busy1), .frame_done(done1));

  typedef struct {
    logic       pre;
    logic [7:0] data;
    int         acc;
  } exp_t;

  exp_t exp0[$];
  exp_t exp1[$];
  int   checks = 0;
  int   errors = 0;
  int   hs0 = 0, hs1 = 0, sent0 = 0, sent1 = 0;
  int   prev_acc[2];
  int   prev_len[2];
  bit   have_prev[2];

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic logic [3:0] samp(input int w);
    return (w == 0) ? {busy0, done0, mark0, space0} : {busy1, done1, mark1, space1};
  endfunction

  function automatic void set_src(input int w, input logic v, input logic [7:0] d);
    if (w == 0) begin
      if0.s_valid = v;
      if0.s_data  = d;
    end else begin
      if1.s_valid = v;
      if1.s_data  = d;
    end
  endfunction

  function automatic logic src_ready(input int w);
    return (w == 0) ? if0.s_ready : if1.s_ready;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (if0.s_valid && if0.s_ready) hs0 <= hs0 + 1;
      if (if1.s_valid && if1.s_ready) hs1 <= hs1 + 1;
    end
  end

  // Present a byte, wait (bounded) for the handshake and push the expected frame.
  task automatic send(input int w, input logic [7:0] b, input int gap);
    exp_t e;
    int   n;
    if (gap > 0) begin
      set_src(w, 1'b0, 8'($urandom));
      repeat (gap) @(posedge clk);
      #1;
    end
    set_src(w, 1'b1, b);
    n = 0;
    forever begin
      @(negedge clk);
      if (src_ready(w)) break;
      n++;
      if (n > 400) begin
        check("accept_timeout", 0, 1);
        set_src(w, 1'b0, 8'h00);
        return;
      end
    end
    @(posedge clk);
    #1;
    e.data = b;
    e.acc  = cyc;
    e.pre  = !(have_prev[w] && (cyc - prev_acc[w] == prev_len[w] + GRD));
    have_prev[w] = 1'b1;
    prev_acc[w]  = cyc;
    prev_len[w]  = ((e.pre ? PRE : 0) + DB + 2) * SYM;
    if (w == 0) begin
      exp0.push_back(e);
      sent0++;
    end else begin
      exp1.push_back(e);
      sent1++;
    end
    set_src(w, 1'b0, 8'($urandom));
  endtask

  task automatic mon(input int w);
    bit         q[$];
    bit         syms[$];
    bit         in_frame = 1'b0;
    bit         first = 1'b1;
    bit         both = 1'b0, early_done = 1'b0, no_busy = 1'b0;
    int         gap = 0, start = 0, nsym, nbad, idx;
    logic [3:0] s;
    logic [7:0] dec;
    exp_t       e;
    forever begin
      @(negedge clk);
      s = samp(w);
      if (!rst_n) begin
        in_frame = 1'b0;
        first    = 1'b1;
        gap      = 0;
        q.delete();
        continue;
      end
      if (s[1] || s[0]) begin
        if (!in_frame) begin
          in_frame = 1'b1;
          start = cyc;
          q.delete();
          both = 1'b0; early_done = 1'b0; no_busy = 1'b0;
          if (!first) check("guard_gap_min", int'(gap >= GRD), 1);
        end
        q.push_back(s[1]);
        if (s[1] && s[0]) both = 1'b1;
        if (s[2]) early_done = 1'b1;
        if (!s[3]) no_busy = 1'b1;
      end else begin
        if (in_frame) begin
          in_frame = 1'b0;
          first = 1'b0;
          gap = 0;
          check("frame_done_pulse", int'(s[2]), 1);
          check("tones_exclusive", int'(both), 0);
          check("frame_done_early", int'(early_done), 0);
          check("busy_in_frame", int'(no_busy), 0);
          if ((w == 0 ? exp0.size() : exp1.size()) == 0) begin
            check("unexpected_frame", 0, 1);
          end else begin
            e = (w == 0) ? exp0.pop_front() : exp1.pop_front();
            syms.delete();
            if (e.pre) for (int i = 0; i < PRE; i++) syms.push_back((i % 2) == 0);
            syms.push_back(1'b0);
            for (int k = 0; k < DB; k++) syms.push_back(w == 1 ? e.data[DB-1-k] : e.data[k]);
            syms.push_back(1'b1);
            nsym = syms.size();
            nbad = 0;
            for (int i = 0; i < q.size(); i++)
              if (i / SYM < nsym && q[i] != syms[i / SYM]) nbad++;
            check("frame_length", q.size(), nsym * SYM);
            check("frame_symbols_bad", nbad, 0);
            check("tone_latency", start, e.acc);
            check("frame_done_cycle", cyc, e.acc + nsym * SYM);
            dec = 8'h00;
            for (int k = 0; k < DB; k++) begin
              idx = ((e.pre ? PRE : 0) + 1 + k) * SYM + SYM / 2;
              if (idx < q.size()) begin
                if (w == 1) dec[DB-1-k] = q[idx];
                else        dec[k]      = q[idx];
              end
            end
            check("decoded_byte", int'(dec), int'(e.data));
          end
        end
        gap++;
      end
    end
  endtask

  initial begin
    fork
      mon(0);
      mon(1);
    join_none
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    have_prev[0] = 1'b0;
    have_prev[1] = 1'b0;
    set_src(0, 1'b0, 8'h00);
    set_src(1, 1'b0, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("rst_mark", int'(mark0), 0);
    check("rst_space", int'(space0), 0);
    check("rst_busy", int'(busy0), 0);
    check("rst_done", int'(done0), 0);
    check("rst_ready", int'(if0.s_ready), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // single byte with preamble, then idle
    send(0, 8'hA5, 0);
    repeat (70) @(posedge clk);
    #1;
    check("idle_busy", int'(busy0), 0);
    check("idle_ready", int'(if0.s_ready), 1);
    check("idle_tones", int'({mark0, space0}), 0);

    // back-to-back burst: second frame skips the preamble
    send(0, 8'h00, 0);
    send(0, 8'hFF, 0);
    repeat (60) @(posedge clk);
    #1;

    // enable dropped during data bit 3
    send(0, 8'h3C, 0);
    repeat (32) @(posedge clk);
    #1;
    enable = 1'b0;
    if0.s_valid = 1'b1;
    if0.s_data  = 8'h99;
    repeat (40) @(posedge clk);
    #1;
    check("disabled_busy", int'(busy0), 0);
    check("disabled_ready", int'(if0.s_ready), 0);
    check("disabled_handshakes", hs0, sent0);
    if0.s_valid = 1'b0;
    enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // asynchronous reset mid-frame
    send(0, 8'h5A, 0);
    repeat (30) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_mark", int'(mark0), 0);
    check("async_rst_space", int'(space0), 0);
    check("async_rst_busy", int'(busy0), 0);
    check("async_rst_ready", int'(if0.s_ready), 0);
    exp0.delete();
    exp1.delete();
    have_prev[0] = 1'b0;
    have_prev[1] = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    send(0, 8'h0F, 0);
    repeat (70) @(posedge clk);
    #1;

    // random bytes, mix of bursts and idle gaps
    for (int i = 0; i < 200; i++) begin
      gap = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(50, 70);
      send(0, 8'($urandom), gap);
    end
    repeat (80) @(posedge clk);
    #1;

    // MSB-first instance
    send(1, 8'h80, 0);
    repeat (70) @(posedge clk);
    #1;

    check("drain_dut0", exp0.size(), 0);
    check("drain_dut1", exp1.size(), 0);
    check("handshakes_dut0", hs0, sent0);
    check("handshakes_dut1", hs1, sent1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
